// File: rtl/dmem_mmio_responder_if.sv
// dmem_mmio_responder_if: processor data-memory bus plus the output FIFO stream
interface dmem_mmio_responder_if;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        irq;
  modport master (
    output address_dmem, data, wren, out_ready,
    input  q_dmem, out_valid, out_data, irq
  );
  modport slave (
    input  address_dmem, data, wren, out_ready,
    output q_dmem, out_valid, out_data, irq
  );
endinterface

// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: dmem drop-in with word RAM plus counter/timer/status/FIFO MMIO page (timer gated by DMEM_MMIO_TIMER_EN)
module dmem_mmio_responder #(
  parameter int RAM_DEPTH  = 2048,
  parameter int FIFO_DEPTH = 8
) (
  input logic clock,
  input logic reset,
  dmem_mmio_responder_if.slave bus
);
  localparam int AW = RAM_DEPTH > 1 ? $clog2(RAM_DEPTH) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [10:0] RAM_MASK = 11'(RAM_DEPTH - 1);
  localparam logic [PW:0] FIFO_FULL = (PW + 1)'(FIFO_DEPTH);
  logic [31:0] ram [RAM_DEPTH];
  logic [31:0] fifo_mem [FIFO_DEPTH];
  logic [31:0] ram_q, mmio_q, count, compare, status, head, rd_val;
  logic [PW:0] wr_ptr, rd_ptr, used;
  logic [AW-1:0] ram_idx;
  logic sel_ram, is_ram, is_mmio, wr_ram, wr_count, wr_status, wr_fifo;
  logic empty, full, pop, push, ovf_set, overflow, timer_flag;
  assign is_ram    = !bus.address_dmem[11];
  assign is_mmio   = bus.address_dmem[11] && bus.address_dmem[10:2] == 9'd0;
  assign ram_idx   = AW'(bus.address_dmem[10:0] & RAM_MASK);
  assign wr_ram    = bus.wren && is_ram && !reset;
  assign wr_count  = bus.wren && is_mmio && bus.address_dmem[1:0] == 2'd0;
  assign wr_status = bus.wren && is_mmio && bus.address_dmem[1:0] == 2'd2;
  assign wr_fifo   = bus.wren && is_mmio && bus.address_dmem[1:0] == 2'd3;
  assign used    = wr_ptr - rd_ptr;
  assign empty   = used == '0;
  assign full    = used == FIFO_FULL;
  assign head    = empty ? 32'd0 : fifo_mem[rd_ptr[PW-1:0]];
  // pop is resolved first, so a push into a full FIFO that is draining this cycle still lands
  assign pop     = !empty && bus.out_ready;
  assign push    = wr_fifo && (!full || pop);
  assign ovf_set = wr_fifo && full && !pop;
  assign status  = {28'd0, overflow, timer_flag, full, empty};
  always_comb begin
    rd_val = '0;
    if (is_mmio)
      rd_val = bus.address_dmem[1:0] == 2'd0 ? count :
               bus.address_dmem[1:0] == 2'd1 ? compare :
               bus.address_dmem[1:0] == 2'd2 ? status : head;
  end
  always_ff @(posedge clock) begin
    if (wr_ram) ram[ram_idx] <= bus.data;
    ram_q <= ram[ram_idx];
    if (push) fifo_mem[wr_ptr[PW-1:0]] <= bus.data;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      sel_ram  <= 1'b0;
      mmio_q   <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      sel_ram  <= is_ram;
      mmio_q   <= rd_val;
      count    <= wr_count ? bus.data : count + 32'd1;
      wr_ptr   <= wr_ptr + (PW + 1)'(push);
      rd_ptr   <= rd_ptr + (PW + 1)'(pop);
      overflow <= ovf_set || (overflow && !(wr_status && bus.data[3]));
    end
  end
`ifdef DMEM_MMIO_TIMER_EN
  logic wr_compare;
  assign wr_compare = bus.wren && is_mmio && bus.address_dmem[1:0] == 2'd1;
  always_ff @(posedge clock) begin
    if (reset) begin
      compare    <= 32'hFFFF_FFFF;
      timer_flag <= 1'b0;
    end else begin
      compare    <= wr_compare ? bus.data : compare;
      timer_flag <= count == compare || (timer_flag && !(wr_status && bus.data[2]));
    end
  end
`else
  assign compare    = '0;
  assign timer_flag = 1'b0;
`endif
  assign bus.q_dmem    = sel_ram ? ram_q : mmio_q;
  assign bus.out_valid = !empty;
  assign bus.out_data  = head;
  assign bus.irq       = timer_flag;
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// tb_dmem_mmio_responder: directed stimulus checked every cycle against a queue/array model
module tb_dmem_mmio_responder;
  localparam int RD = 2048;
  localparam int FD = 8;
`ifdef DMEM_MMIO_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;
  logic [31:0] m_ram [int];
  logic [31:0] m_fifo [$];
  logic [31:0] m_q, m_cnt, m_cmp;
  bit m_qk, m_tf, m_ovf;
  dmem_mmio_responder_if bus ();
  dmem_mmio_responder #(.RAM_DEPTH(RD), .FIFO_DEPTH(FD)) dut (.clock(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask
  task automatic step(input logic [11:0] a, input logic [31:0] d, input logic w, input logic r);
    bus.address_dmem = a;
    bus.data = d;
    bus.wren = w;
    bus.out_ready = r;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle(input logic r);
    step(12'h804, 32'd0, 1'b0, r);
  endtask
  always @(posedge clk) begin : model
    int idx;
    bit pop, match;
    idx = int'(bus.address_dmem[10:0]) % RD;
    if (rst) begin
      m_q = 0; m_qk = 1; m_cnt = 0; m_tf = 0; m_ovf = 0;
      m_cmp = TIMER ? 32'hFFFF_FFFF : 32'd0;
      m_fifo.delete();
    end else begin
      pop = m_fifo.size() > 0 && bus.out_ready;
      match = TIMER && m_cnt == m_cmp;
      if (!bus.address_dmem[11]) begin
        m_qk = m_ram.exists(idx);
        m_q = m_qk ? m_ram[idx] : 32'd0;
      end else begin
        m_qk = 1;
        case (bus.address_dmem)
          12'h800: m_q = m_cnt;
          12'h801: m_q = m_cmp;
          12'h802: m_q = {28'd0, m_ovf, m_tf, m_fifo.size() == FD, m_fifo.size() == 0};
          12'h803: m_q = m_fifo.size() > 0 ? m_fifo[0] : 32'd0;
          default: m_q = 32'd0;
        endcase
      end
      m_cnt = (bus.wren && bus.address_dmem == 12'h800) ? bus.data : m_cnt + 32'd1;
      if (TIMER && bus.wren && bus.address_dmem == 12'h801) m_cmp = bus.data;
      if (bus.wren && bus.address_dmem == 12'h802) begin
        if (bus.data[2]) m_tf = 0;
        if (bus.data[3]) m_ovf = 0;
      end
      if (match) m_tf = 1;
      if (pop) void'(m_fifo.pop_front());
      if (bus.wren && bus.address_dmem == 12'h803) begin
        if (m_fifo.size() < FD) m_fifo.push_back(bus.data);
        else m_ovf = 1;
      end
      if (bus.wren && !bus.address_dmem[11]) m_ram[idx] = bus.data;
    end
  end
  always @(negedge clk) begin
    if (cmp_en) begin
      if (m_qk) chk("q_dmem", bus.q_dmem, m_q);
      chk("out_valid", 32'(bus.out_valid), 32'(m_fifo.size() > 0));
      chk("out_data", bus.out_data, m_fifo.size() > 0 ? m_fifo[0] : 32'd0);
      chk("irq", 32'(bus.irq), 32'(m_tf));
    end
  end
  initial begin
    bus.address_dmem = 12'h804;
    bus.data = 32'd0;
    bus.wren = 1'b0;
    bus.out_ready = 1'b0;
    idle(1'b0);
    idle(1'b0);
    chk("reset_q", bus.q_dmem, 32'd0);
    chk("reset_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_data", bus.out_data, 32'd0);
    chk("reset_irq", 32'(bus.irq), 32'd0);
    cmp_en = 1'b1;
    rst = 1'b0;
    step(12'h010, 32'hDEAD_BEEF, 1'b1, 1'b0);
    step(12'h010, 32'd0, 1'b0, 1'b0);
    chk("ram_readback", bus.q_dmem, 32'hDEAD_BEEF);
    step(12'h810, 32'd0, 1'b0, 1'b0);
    chk("unmapped_810", bus.q_dmem, 32'd0);
    step(12'h020, 32'd5, 1'b1, 1'b0);
    step(12'h020, 32'd9, 1'b1, 1'b0);
    chk("rdw_old", bus.q_dmem, 32'd5);
    step(12'h020, 32'd0, 1'b0, 1'b0);
    chk("rdw_new", bus.q_dmem, 32'd9);
    for (int i = 1; i <= 8; i++) step(12'h803, 32'(i), 1'b1, 1'b0);
    step(12'h802, 32'd0, 1'b0, 1'b0);
    chk("status_full", bus.q_dmem, 32'h2);
    step(12'h803, 32'd9, 1'b1, 1'b0);
    step(12'h802, 32'd0, 1'b0, 1'b0);
    chk("status_ovf", bus.q_dmem, 32'hA);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_order", bus.out_data, 32'(i));
      idle(1'b1);
    end
    chk("drained_valid", 32'(bus.out_valid), 32'd0);
    step(12'h802, 32'd0, 1'b0, 1'b0);
    chk("status_empty_ovf", bus.q_dmem, 32'h9);
    step(12'h802, 32'h8, 1'b1, 1'b0);
    step(12'h802, 32'd0, 1'b0, 1'b0);
    chk("status_w1c_ovf", bus.q_dmem, 32'h1);
    for (int i = 0; i < 8; i++) step(12'h803, 32'h10 + 32'(i), 1'b1, 1'b0);
    step(12'h803, 32'hAA, 1'b1, 1'b1);
    step(12'h802, 32'd0, 1'b0, 1'b0);
    chk("full_push_pop", bus.q_dmem, 32'h2);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_aa", bus.out_data, i == 8 ? 32'hAA : 32'h10 + 32'(i));
      idle(1'b1);
    end
    step(12'h800, 32'd100, 1'b1, 1'b0);
    step(12'h800, 32'd0, 1'b0, 1'b0);
    chk("count_load", bus.q_dmem, 32'd100);
    if (TIMER) begin
      step(12'h800, 32'hFFFF_FFFD, 1'b1, 1'b0);
      step(12'h801, 32'd1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) idle(1'b0);
      chk("irq_before", 32'(bus.irq), 32'd0);
      idle(1'b0);
      chk("irq_match", 32'(bus.irq), 32'd1);
      idle(1'b0);
      step(12'h802, 32'h4, 1'b1, 1'b0);
      chk("irq_w1c", 32'(bus.irq), 32'd0);
      step(12'h801, 32'd0, 1'b0, 1'b0);
      chk("compare_read", bus.q_dmem, 32'd1);
    end else begin
      step(12'h801, 32'd1, 1'b1, 1'b0);
      step(12'h801, 32'd0, 1'b0, 1'b0);
      chk("compare_absent", bus.q_dmem, 32'd0);
      for (int i = 0; i < 4; i++) idle(1'b0);
      chk("irq_absent", 32'(bus.irq), 32'd0);
    end
    for (int i = 1; i <= 3; i++) step(12'h803, 32'(i), 1'b1, 1'b0);
    rst = 1'b1;
    step(12'h803, 32'h55, 1'b1, 1'b0);
    rst = 1'b0;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_q", bus.q_dmem, 32'd0);
    step(12'h800, 32'd0, 1'b0, 1'b0);
    chk("rst_count", bus.q_dmem, 32'd0);
    step(12'h802, 32'd0, 1'b0, 1'b0);
    chk("rst_status", bus.q_dmem, 32'h1);
    idle(1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
